pipeline_debug_ctrl: RTL
========================

Name: pipeline_debug_ctrl

Overview:
Debug sequencer for the 5-stage MIPS pipeline. It drives the pipeline's global `enable`, which runs, pauses, single-steps and halt-drains the core. It snapshots the PC, the four inter-stage latch buses and optionally the register file, then streams the snapshot byte-wise over a valid/ready TX port. Commands arrive as bytes on a valid/ready RX port, normally from the board UART receiver; the TX port feeds the UART transmitter.

Parameters:
HALT_WORD, 32'hFFFF_FFFF, instruction word at IF that triggers halt-drain
DRAIN_CYCLES, 4, enabled cycles issued after the halt word is observed
DUMP_REGS, 1, 1 = append the 1024-bit register file to the frame; 0 = omit it

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
cmd_data  in  8  command byte
cmd_valid  in  1  command byte present
cmd_ready  out  1  controller accepts a command this cycle
tx_data  out  8  frame byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts tx_data
instruccion  in  32  word currently at IF
pc  in  8  pipeline PC
if_id  in  40  IF/ID latch bus
id_ex  in  144  ID/EX latch bus
ex_m  in  80  EX/MEM latch bus
m_wb  in  80  MEM/WB latch bus
registros  in  1024  register file, flattened
pipe_enable  out  1  pipeline enable (registered)
halted  out  1  a halt-drain completed
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high, wins over everything): state=IDLE, pipe_enable=0, tx_valid=0, tx_data=0, cmd_ready=1, halted=0, busy=0, byte index=0, drain count=0, cycle counter=0. Reset mid-dump aborts the frame; no further bytes are sent.
- Command handshake:
  - A command is accepted on the edge where cmd_valid&cmd_ready=1.
  - cmd_ready=1 only in IDLE and RUN.
  - Commands: 0x52 'R' run, 0x53 'S' step, 0x44 'D' dump, 0x50 'P' pause.
  - Unknown bytes are accepted and ignored.
  - In RUN only 'P' acts; all other bytes are consumed and ignored.
- States:
  - IDLE: 'R' -> RUN; 'S' -> STEP; 'D' -> SNAP. 'R' and 'S' clear halted.
  - RUN: pipe_enable=1. If instruccion==HALT_WORD -> DRAIN with drain count=0. Else if 'P' is accepted -> IDLE (no dump). If both occur in the same cycle, halt wins and 'P' is consumed.
  - DRAIN: pipe_enable=1, drain count increments each cycle; when it reaches DRAIN_CYCLES-1 -> SNAP and set halted. This gives exactly DRAIN_CYCLES enabled cycles after the halt cycle.
  - STEP: pipe_enable=1 for exactly one cycle -> SNAP. No halt detection in STEP.
  - SNAP: pipe_enable=0; one cycle; the frame register captures all inputs; byte index=0 -> SEND.
  - SEND: presents frame bytes; -> IDLE after the last byte handshake.
- pipe_enable is a registered decode of the next state (RUN/DRAIN/STEP). Example: 'R' accepted at edge N gives pipe_enable=1 during cycle N+1.
- Cycle counter:
  - 32 bits; increments on every cycle with pipe_enable=1; wraps 0xFFFF_FFFF -> 0.
  - Cleared only by rst.
- Frame, sent MSB byte first, concatenated in this order: cycle_counter[31:0], pc, if_id, id_ex, ex_m, m_wb, then registros if DUMP_REGS=1.
  - Length: 48 bytes if DUMP_REGS=0; 176 bytes if DUMP_REGS=1.
  - Byte index width: 8 bits.
- TX handshake:
  - tx_valid rises in the first SEND cycle.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - On tx_valid&tx_ready the index advances; the next byte is presented the following cycle with no bubble.
  - After the last byte, tx_valid=0 and state=IDLE.
  - tx_ready asserted with tx_valid=0 has no effect.
- halted stays 1 until the next accepted 'R'/'S' or rst. A 'D' while halted keeps halted=1.
- busy=1 in every state except IDLE.

Test Plan:
1. rst high 2 cycles, then check outputs. -> pipe_enable=0, tx_valid=0, cmd_ready=1, busy=0, halted=0.
2. Send 'S', tx_ready=1 constant, DUMP_REGS=0. -> pipe_enable=1 for exactly 1 cycle; 48 bytes follow; first 4 bytes are 00 00 00 01; bytes 5.. match the captured pc/if_id; then IDLE.
3. 'R', then instruccion=32'hFFFF_FFFF on the 10th enabled cycle. -> exactly 4 further enabled cycles; cycle counter in frame = 14; halted=1 after the frame.
4. 'R', wait 20 cycles, 'P' with the halt word in the same cycle. -> DRAIN entered (halt wins), dump follows; separately, 'P' alone -> pipe_enable drops next cycle, no tx_valid.
5. 'D' with tx_ready toggling 1/0 randomly, DUMP_REGS=1. -> 176 bytes, tx_data stable while stalled, registros bytes last; cmd_valid pulses during SEND are not accepted (cmd_ready=0).
6. rst asserted at byte 20 of a dump. -> next cycle tx_valid=0, state IDLE, counter=0; a subsequent 'D' restarts at byte 0 with counter bytes 00 00 00 00.

Source files
------------

// File: rtl/pipeline_debug_ctrl.sv
// Debug sequencer for the 5-stage pipeline: run/pause/step/halt-drain control of the global
// enable, snapshot of PC, latch buses and register file, streamed MSB-first over a byte port.
module pipeline_debug_ctrl #(
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter bit          DUMP_REGS    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    cmd_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [31:0]   instruccion,
    input  logic [7:0]    pc,
    input  logic [39:0]   if_id,
    input  logic [143:0]  id_ex,
    input  logic [79:0]   ex_m,
    input  logic [79:0]   m_wb,
    input  logic [1023:0] registros,
    output logic          pipe_enable,
    output logic          halted,
    output logic          busy
);

    localparam int unsigned FrameBits = DUMP_REGS ? 1408 : 384;
    localparam int unsigned NumBytes  = FrameBits / 8;
    localparam logic [7:0]  LastIdx   = 8'(NumBytes - 1);
    localparam logic [7:0]  LastDrain = 8'(DRAIN_CYCLES - 1);

    localparam logic [7:0] CmdRun   = 8'h52;
    localparam logic [7:0] CmdStep  = 8'h53;
    localparam logic [7:0] CmdDump  = 8'h44;
    localparam logic [7:0] CmdPause = 8'h50;

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StStep, StSnap, StSend} state_e;

    state_e                 state_q, state_d;
    logic                   pipe_en_q, pipe_en_d;
    logic                   halted_q, halted_d;
    logic [7:0]             idx_q, idx_d;
    logic [7:0]             drain_q, drain_d;
    logic [31:0]            cycle_q;
    logic [FrameBits-1:0]   frame_q, frame_d;
    logic [FrameBits-1:0]   snap_w;
    logic                   cmd_fire;
    logic                   tx_fire;

    if (DUMP_REGS) begin : g_regs
        assign snap_w = {cycle_q, pc, if_id, id_ex, ex_m, m_wb, registros};
    end else begin : g_no_regs
        logic unused_regs;
        assign snap_w      = {cycle_q, pc, if_id, id_ex, ex_m, m_wb};
        assign unused_regs = ^registros;
    end

    assign cmd_ready   = (state_q == StIdle) || (state_q == StRun);
    assign tx_valid    = (state_q == StSend);
    assign busy        = (state_q != StIdle);
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign tx_fire     = tx_valid && tx_ready;
    // Frame is a shift register, so the byte on the wire is always the top byte.
    assign tx_data     = frame_q[FrameBits-1 -: 8];
    assign pipe_enable = pipe_en_q;
    assign halted      = halted_q;

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        frame_d  = frame_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    case (cmd_data)
                        CmdRun: begin
                            state_d  = StRun;
                            halted_d = 1'b0;
                        end
                        CmdStep: begin
                            state_d  = StStep;
                            halted_d = 1'b0;
                        end
                        CmdDump: state_d = StSnap;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // Halt word beats a simultaneous pause; the pause byte is still consumed.
                if (instruccion == HALT_WORD) begin
                    state_d = StDrain;
                    drain_d = 8'd0;
                end else if (cmd_fire && (cmd_data == CmdPause)) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (drain_q == LastDrain) begin
                    state_d  = StSnap;
                    halted_d = 1'b1;
                end else begin
                    drain_d = drain_q + 8'd1;
                end
            end
            StStep: state_d = StSnap;
            StSnap: begin
                frame_d = snap_w;
                idx_d   = 8'd0;
                state_d = StSend;
            end
            StSend: begin
                if (tx_fire) begin
                    frame_d = frame_q << 8;
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = 8'd0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        pipe_en_d = (state_d == StRun) || (state_d == StDrain) || (state_d == StStep);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pipe_en_q <= 1'b0;
            halted_q  <= 1'b0;
            idx_q     <= 8'd0;
            drain_q   <= 8'd0;
            cycle_q   <= 32'd0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            pipe_en_q <= pipe_en_d;
            halted_q  <= halted_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            cycle_q   <= cycle_q + 32'(pipe_en_q);
            frame_q   <= frame_d;
        end
    end

endmodule
